// File: rtl/apb3_fifo_slave.sv
// APB3 slave fronting an 8x32 push FIFO that drains to a fabric consumer.
// Control/status registers, scratch register and a level interrupt to the MSS.
module apb3_fifo_slave (
  input  logic        FAB_CLK,
  input  logic        FAB_RESET,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [7:0]  PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic [31:0] DATA_OUT,
  output logic        DATA_VALID,
  input  logic        DATA_READY,
  output logic        IRQ
);

  typedef enum logic [1:0] {IDLE, SETUP, RWAIT, DONE} state_t;

  state_t      state_reg, state_next;
  logic        en_reg, irq_en_reg, ovf_reg, irq_reg;
  logic [31:0] scratch_reg, rdata_reg;
  logic        rerr_reg;
  logic [31:0] mem [0:7];
  logic [2:0]  wr_ptr_reg, rd_ptr_reg;
  logic [3:0]  count_reg;

  logic        access, addr_ok, full, empty, valid;
  logic        wr_fire, rd_fire, wr_err, rd_err, push, pop, flush;
  logic [1:0]  idx;
  logic [31:0] rd_value;

  assign access  = PSEL & PENABLE;
  assign addr_ok = (PADDR[7:4] == 4'd0) && (PADDR[1:0] == 2'd0);
  assign idx     = PADDR[3:2];
  assign full    = (count_reg == 4'd8);
  assign empty   = (count_reg == 4'd0);

  assign wr_fire = (state_reg == SETUP) & access & PWRITE & ~FAB_RESET;
  assign rd_fire = (state_reg == SETUP) & access & ~PWRITE & ~FAB_RESET;
  assign wr_err  = ~addr_ok | ((idx == 2'd2) & (full | ~en_reg));
  assign rd_err  = ~addr_ok | (idx == 2'd2);

  // FULL is taken before any same-edge pop, so a push to a full FIFO is always rejected
  assign push  = wr_fire & addr_ok & (idx == 2'd2) & ~full & en_reg;
  assign flush = wr_fire & addr_ok & (idx == 2'd0) & PWDATA[2];
  assign valid = en_reg & ~empty & ~FAB_RESET;
  assign pop   = valid & DATA_READY;

  assign DATA_VALID = valid;
  assign DATA_OUT   = valid ? mem[rd_ptr_reg] : 32'd0;
  assign IRQ        = irq_reg & ~FAB_RESET;

  always_comb begin
    rd_value = 32'd0;
    case (idx)
      2'd0: rd_value = {30'd0, irq_en_reg, en_reg};
      2'd1: rd_value = {25'd0, ovf_reg, empty, full, count_reg};
      2'd3: rd_value = scratch_reg;
      default: rd_value = 32'd0;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    PREADY     = 1'b0;
    PSLVERR    = 1'b0;
    PRDATA     = 32'd0;
    case (state_reg)
      IDLE: begin
        if (PSEL & ~PENABLE) state_next = SETUP;
      end
      SETUP: begin
        if (~PSEL) begin
          state_next = IDLE;
        end else if (PENABLE) begin
          if (PWRITE) begin
            state_next = DONE;
            PREADY     = 1'b1;
            PSLVERR    = wr_err;
          end else begin
            state_next = RWAIT;
          end
        end
      end
      RWAIT: begin
        if (access) begin
          state_next = DONE;
          PREADY     = 1'b1;
          PSLVERR    = rerr_reg;
          PRDATA     = rdata_reg;
        end else begin
          state_next = IDLE;
        end
      end
      DONE: begin
        // a master issuing back-to-back transfers puts its next setup here
        state_next = (PSEL & ~PENABLE) ? SETUP : IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (FAB_RESET) begin
      PREADY  = 1'b0;
      PSLVERR = 1'b0;
      PRDATA  = 32'd0;
    end
  end

  always_ff @(posedge FAB_CLK) begin
    if (FAB_RESET) begin
      state_reg   <= IDLE;
      en_reg      <= 1'b0;
      irq_en_reg  <= 1'b0;
      ovf_reg     <= 1'b0;
      irq_reg     <= 1'b0;
      scratch_reg <= 32'd0;
      rdata_reg   <= 32'd0;
      rerr_reg    <= 1'b0;
      wr_ptr_reg  <= 3'd0;
      rd_ptr_reg  <= 3'd0;
      count_reg   <= 4'd0;
    end else begin
      state_reg <= state_next;
      irq_reg   <= irq_en_reg & (ovf_reg | (en_reg & empty));
      if (rd_fire) begin
        rdata_reg <= rd_err ? 32'd0 : rd_value;
        rerr_reg  <= rd_err;
      end
      if (wr_fire & addr_ok) begin
        case (idx)
          2'd0: begin
            en_reg     <= PWDATA[0];
            irq_en_reg <= PWDATA[1];
          end
          2'd1: if (PWDATA[6]) ovf_reg <= 1'b0;
          2'd2: if (full) ovf_reg <= 1'b1;
          default: scratch_reg <= PWDATA;
        endcase
      end
      // flush wins over a pop on the same edge
      if (flush) begin
        wr_ptr_reg <= 3'd0;
        rd_ptr_reg <= 3'd0;
        count_reg  <= 4'd0;
      end else begin
        if (push) wr_ptr_reg <= wr_ptr_reg + 3'd1;
        if (pop)  rd_ptr_reg <= rd_ptr_reg + 3'd1;
        count_reg <= count_reg + {3'd0, push} - {3'd0, pop};
      end
    end
  end

  always_ff @(posedge FAB_CLK) begin
    if (push) mem[wr_ptr_reg] <= PWDATA;
  end

endmodule

// File: tb/tb_apb3_fifo_slave.sv
// Self-checking bench: APB responses go through a scoreboard queue; FIFO output,
// IRQ and idle bus values are checked every cycle against a queue-based model.
module tb_apb3_fifo_slave;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [7:0]  paddr = 8'd0;
  logic [31:0] pwdata = 32'd0;
  logic        dready = 1'b0;
  logic [31:0] prdata, data_out;
  logic        pready, pslverr, data_valid, irq;

  always #5 clk = ~clk;

  apb3_fifo_slave dut (
    .FAB_CLK(clk), .FAB_RESET(rst),
    .PSEL(psel), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata),
    .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr),
    .DATA_OUT(data_out), .DATA_VALID(data_valid), .DATA_READY(dready),
    .IRQ(irq)
  );

  typedef struct { bit is_read; bit err; logic [31:0] data; } resp_t;
  resp_t       exp_q[$];
  logic [31:0] m_q[$];
  bit          m_en = 0, m_irq_en = 0, m_ovf = 0, exp_irq = 0;
  logic [31:0] m_scratch = 32'd0;
  bit          pend_wr = 0;
  logic [7:0]  pend_addr = 8'd0;
  logic [31:0] pend_data = 32'd0;
  bit          rand_ready = 0;
  int          n_cmp = 0, n_bad = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, expv, $time);
    end
  endfunction

  function automatic bit addr_ok(input logic [7:0] a);
    return (a[7:4] == 4'd0) && (a[1:0] == 2'd0);
  endfunction

  function automatic logic [31:0] model_read(input logic [7:0] a);
    logic [31:0] v;
    v = 32'd0;
    if (addr_ok(a)) begin
      case (a[3:2])
        2'd0: v = {30'd0, m_irq_en, m_en};
        2'd1: v = {25'd0, m_ovf, m_q.size() == 0, m_q.size() == 8, 4'(m_q.size())};
        2'd3: v = m_scratch;
        default: v = 32'd0;
      endcase
    end
    return v;
  endfunction

  // Effect of one rising edge given the inputs presented during the preceding cycle
  function automatic void model_edge();
    bit full_pre, pop, flush, do_push;
    full_pre = (m_q.size() == 8);
    pop      = m_en && (m_q.size() != 0) && dready;
    flush    = 0;
    do_push  = 0;
    if (rst) begin
      m_q.delete();
      m_en = 0; m_irq_en = 0; m_ovf = 0; m_scratch = 32'd0;
      exp_irq = 0; pend_wr = 0;
      return;
    end
    exp_irq = m_irq_en && (m_ovf || (m_en && m_q.size() == 0));
    if (pend_wr && addr_ok(pend_addr)) begin
      case (pend_addr[3:2])
        2'd0: begin m_en = pend_data[0]; m_irq_en = pend_data[1]; flush = pend_data[2]; end
        2'd1: if (pend_data[6]) m_ovf = 0;
        2'd2: begin
          if (full_pre) m_ovf = 1;
          else if (m_en) do_push = 1;
        end
        default: m_scratch = pend_data;
      endcase
    end
    pend_wr = 0;
    if (flush) m_q.delete();
    else begin
      if (pop) void'(m_q.pop_front());
      if (do_push) m_q.push_back(pend_data);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    if (rand_ready) dready = 1'($urandom_range(0, 1));
  endtask

  task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
    resp_t r;
    psel = 1; penable = 0; pwrite = 1; paddr = a; pwdata = d;
    tick();
    penable = 1;
    r.is_read = 0;
    r.data    = 32'd0;
    r.err     = !addr_ok(a) || (a[3:2] == 2'd2 && (m_q.size() == 8 || !m_en));
    exp_q.push_back(r);
    pend_wr = 1; pend_addr = a; pend_data = d;
    tick();
    psel = 0; penable = 0;
    tick();
    $display("write addr=%02h data=%08h err_expected=%0d", a, d, r.err);
  endtask

  task automatic apb_read(input logic [7:0] a);
    resp_t r;
    psel = 1; penable = 0; pwrite = 0; paddr = a;
    tick();
    penable = 1;
    r.is_read = 1;
    r.err     = !addr_ok(a) || (a[3:2] == 2'd2);
    r.data    = model_read(a);
    tick();
    exp_q.push_back(r);
    tick();
    psel = 0; penable = 0;
    tick();
    $display("read  addr=%02h data_expected=%08h err_expected=%0d", a, r.data, r.err);
  endtask

  always @(negedge clk) begin
    resp_t r;
    if (rst) begin
      chk("rst_pready", 32'(pready), 32'd0);
      chk("rst_pslverr", 32'(pslverr), 32'd0);
      chk("rst_prdata", prdata, 32'd0);
      chk("rst_data_valid", 32'(data_valid), 32'd0);
      chk("rst_data_out", data_out, 32'd0);
      chk("rst_irq", 32'(irq), 32'd0);
    end else begin
      chk("data_valid", 32'(data_valid), 32'(m_en && m_q.size() != 0));
      if (m_en && m_q.size() != 0) chk("data_out", data_out, m_q[0]);
      chk("irq", 32'(irq), 32'(exp_irq));
      if (exp_q.size() != 0) begin
        r = exp_q.pop_front();
        chk("pready", 32'(pready), 32'd1);
        chk("pslverr", 32'(pslverr), 32'(r.err));
        if (r.is_read && !r.err) chk("prdata", prdata, r.data);
      end else begin
        chk("pready_idle", 32'(pready), 32'd0);
        chk("pslverr_idle", 32'(pslverr), 32'd0);
        chk("prdata_idle", prdata, 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

  initial begin
    logic [7:0]  a;
    logic [31:0] d;
    repeat (3) tick();
    rst = 0;
    tick();

    // enable + irq enable on an empty FIFO
    apb_write(8'h00, 32'h3);
    apb_read(8'h04);

    // fill to full, then overflow
    dready = 0;
    for (int i = 1; i <= 8; i++) apb_write(8'h08, 32'h11 * i);
    apb_read(8'h04);
    apb_write(8'h08, 32'h99);
    apb_read(8'h04);
    apb_write(8'h04, 32'h40);

    // drain, then refill across the pointer wrap
    dready = 1;
    repeat (10) tick();
    dready = 0;
    apb_read(8'h04);
    for (int i = 0; i < 3; i++) apb_write(8'h08, 32'hA1 + i);
    dready = 1;
    repeat (5) tick();
    dready = 0;

    // undecoded / illegal accesses
    apb_write(8'h10, 32'h1234);
    apb_read(8'h08);
    apb_write(8'h0D, 32'hFFFF_FFFF);
    apb_read(8'h44);
    apb_read(8'h00);

    // flush with a concurrent pop
    for (int i = 0; i < 5; i++) apb_write(8'h08, 32'hC0 + i);
    dready = 1;
    apb_write(8'h00, 32'h5);
    dready = 0;
    apb_read(8'h00);
    apb_read(8'h04);

    // EN=0 holds contents and rejects pushes
    apb_write(8'h08, 32'hE1);
    apb_write(8'h08, 32'hE2);
    apb_write(8'h00, 32'h0);
    dready = 1;
    repeat (3) tick();
    apb_write(8'h08, 32'hE3);
    apb_write(8'h00, 32'h1);
    repeat (4) tick();
    dready = 0;

    // reset during the wait state of a read
    apb_write(8'h0C, 32'hDEADBEEF);
    psel = 1; penable = 0; pwrite = 0; paddr = 8'h0C;
    tick();
    penable = 1;
    tick();
    rst = 1;
    tick();
    rst = 0;
    tick();
    psel = 0; penable = 0;
    tick();
    $display("read  addr=0c aborted by reset");
    apb_read(8'h0C);

    // randomized traffic
    rand_ready = 1;
    apb_write(8'h00, 32'h3);
    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(0, 7))
        0:       a = 8'h00;
        1:       a = 8'h04;
        2, 3, 4: a = 8'h08;
        5:       a = 8'h0C;
        default: a = 8'($urandom_range(0, 255));
      endcase
      if (a == 8'h00)
        d = {29'd0, ($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)), ($urandom_range(0, 4) != 0)};
      else
        d = $urandom;
      if ($urandom_range(0, 2) != 0) apb_write(a, d);
      else apb_read(a);
    end
    rand_ready = 0;
    dready = 0;
    repeat (3) tick();

    chk("responses_pending", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/apb3_fifo_slave.md
APB3_FIFO_SLAVE -- requirements
Module: apb3_fifo_slave

Interface
REQ-001 FAB_CLK  in  1  single clock for all logic; all ports sampled/driven on rising edge.
REQ-002 FAB_RESET  in  1  synchronous, active-high reset.
REQ-003 PSEL  in  1  APB3 select from MSS master.
REQ-004 PENABLE  in  1  APB3 access-phase strobe.
REQ-005 PWRITE  in  1  1 = write, 0 = read.
REQ-006 PADDR  in  8  byte address; only PADDR[3:0] decoded, PADDR[7:4] must be 0.
REQ-007 PWDATA  in  32  write data.
REQ-008 PRDATA  out  32  read data; 0 except in the read completion cycle.
REQ-009 PREADY  out  1  transfer-complete indication.
REQ-010 PSLVERR  out  1  error; 0 whenever PREADY=0.
REQ-011 DATA_OUT  out  32  FIFO head word to fabric consumer.
REQ-012 DATA_VALID  out  1  FIFO non-empty and CTRL.EN=1.
REQ-013 DATA_READY  in  1  consumer pop; pop occurs when DATA_VALID and DATA_READY both 1.
REQ-014 IRQ  out  1  level interrupt to MSS.

Function
REQ-015 Register map: 0x00 CTRL RW; 0x04 STATUS RO; 0x08 TXDATA WO; 0x0C SCRATCH RW (32 bits).
REQ-016 CTRL: bit0 EN, bit1 IRQ_EN, bit2 FLUSH (write-1 self-clearing, reads 0); bits 31:3 read 0.
REQ-017 STATUS: [3:0] COUNT (0..8), bit4 FULL, bit5 EMPTY, bit6 OVF sticky; write-1 to bit6 at 0x04 clears OVF, other bits ignored.
REQ-018 FIFO: 8 entries x 32 bits, 3-bit read/write pointers wrapping 7->0, separate 4-bit count.
REQ-019 Setup phase (PSEL=1, PENABLE=0): no state change, PREADY=0.
REQ-020 Write access: PREADY=1 in the first access cycle (zero wait states); register update on that edge.
REQ-021 Read access: PREADY=0 in first access cycle while PRDATA is registered; PREADY=1 with valid PRDATA in second access cycle (one wait state).
REQ-022 Slave returns to IDLE after any completed transfer; PSEL dropping mid-access aborts with no state change.
REQ-023 PSLVERR=1 with PREADY=1 on: undecoded address (incl. PADDR[7:4]!=0 or PADDR[1:0]!=0), read of 0x08, write of TXDATA while FULL or EN=0.
REQ-024 Errored write leaves FIFO and registers unchanged; write to TXDATA while FULL additionally sets OVF.
REQ-025 FULL is evaluated before a same-cycle pop: push to full FIFO is rejected even if a pop occurs on that edge.
REQ-026 Simultaneous push and pop on a non-full, non-empty FIFO: both occur, COUNT unchanged.
REQ-027 Push to empty FIFO: DATA_VALID=1 the cycle after the completing edge (if EN=1).
REQ-028 DATA_READY with DATA_VALID=0: no effect.
REQ-029 FLUSH: pointers and COUNT cleared on the write edge; a pop on the same edge is discarded; OVF unaffected.
REQ-030 EN=0: DATA_VALID=0, FIFO contents held.
REQ-031 IRQ = IRQ_EN & (OVF | (EN & EMPTY)), registered (one cycle after condition).
REQ-032 FSM states: IDLE, SETUP, RWAIT, DONE; IDLE->SETUP on PSEL&!PENABLE; SETUP->DONE on write; SETUP->RWAIT on read; RWAIT->DONE; DONE->IDLE.

Reset
REQ-033 On FAB_RESET=1 at a clock edge: CTRL=0, SCRATCH=0, OVF=0, pointers/COUNT=0, FSM=IDLE.
REQ-034 During and after reset: PREADY=0, PSLVERR=0, PRDATA=0, DATA_VALID=0, IRQ=0, DATA_OUT=0.
REQ-035 Reset mid-transfer aborts the transfer; master sees no PREADY for it.

Verification
REQ-036 Write 0x00=0x3, read 0x04 -> PREADY low one access cycle then high, PRDATA=0x00000020, IRQ=1.
REQ-037 EN=1, write 0x08 eight times (0x11..0x88) with DATA_READY=0 -> STATUS=0x00000018; 9th write -> PSLVERR=1, STATUS bit6=1.
REQ-038 Full FIFO, DATA_READY=1 for 8 cycles -> DATA_OUT 0x11..0x88 in order, then DATA_VALID=0, COUNT=0 (pointer wrap exercised by refill of 3 words, pop yields them in order).
REQ-039 Write 0x10 and read 0x08 -> each completes with PREADY=1, PSLVERR=1, no register change.
REQ-040 FIFO holding 5 words, write CTRL=0x5 (FLUSH) with DATA_READY=1 -> next cycle COUNT=0, DATA_VALID=0, CTRL reads 0x1.
REQ-041 Assert FAB_RESET during read RWAIT of SCRATCH=0xDEADBEEF -> no PREADY, SCRATCH reads 0 afterward.
